// File: rtl/aon_mem_arbiter_if.sv
// Request/grant bundle between three requesters and the always-on store arbiter.
// Requester i owns bit i of req/lock/wr, bits [2i+1:2i] of addr_in and [16i+15:16i] of wdata_in.
interface aon_mem_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  wr;
    logic [5:0]  addr_in;
    logic [47:0] wdata_in;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        busy;
    logic        timeout_err;

    modport master (
        output req, lock, wr, addr_in, wdata_in,
        input  gnt, done, rdata, busy, timeout_err
    );

    modport slave (
        input  req, lock, wr, addr_in, wdata_in,
        output gnt, done, rdata, busy, timeout_err
    );
endinterface

// File: rtl/aon_mem_arbiter.sv
// Three-requester arbiter in front of a 4x16 always-on store, with lock/hold and hold timeout.
// Optional macro AON_ARB_ROUND_ROBIN_EN: round-robin arbitration instead of fixed priority.
module aon_mem_arbiter #(
    parameter int TIMEOUT = 63,
    parameter int NREQ    = 3
) (
    input  logic             clk,
    input  logic             reset,
    aon_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARB    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [1:0] LAST = 2'(NREQ - 1);
    localparam logic [5:0] TMO  = 6'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [1:0]  win;
    logic [1:0]  arb_idx;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        busy;
    logic        timeout_err;
    logic [5:0]  hold_timer;
    logic        timer_hit;
    logic [15:0] store [4];
    logic        sel_wr;
    logic [1:0]  sel_addr;
    logic [15:0] sel_wdata;
    logic        win_lock;
    logic        win_req;

    function automatic logic [1:0] pick_first(input logic [2:0] r, input logic [1:0] a,
                                              input logic [1:0] b, input logic [1:0] c);
        if (r[a]) begin
            return a;
        end else if (r[b]) begin
            return b;
        end else begin
            return c;
        end
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

`ifdef AON_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Search order starts just after the previous winner.
    always_comb begin
        case (rr_ptr)
            2'd0:    arb_idx = pick_first(bus.req, 2'd1, 2'd2, 2'd0);
            2'd1:    arb_idx = pick_first(bus.req, 2'd2, 2'd0, 2'd1);
            default: arb_idx = pick_first(bus.req, 2'd0, 2'd1, LAST);
        endcase
    end

    // Remember the last arbitrated winner; hold re-accesses do not move it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= LAST;
        end else if ((state == ARB) && (|bus.req)) begin
            rr_ptr <= arb_idx;
        end else begin
            rr_ptr <= rr_ptr;
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        arb_idx = pick_first(bus.req, 2'd0, 2'd1, LAST);
    end
`endif

    // Route the current owner's request fields.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = 2'd0;
        sel_wdata = 16'h0000;
        win_lock  = 1'b0;
        win_req   = 1'b0;
        case (win)
            2'd0: begin
                sel_wr    = bus.wr[0];
                sel_addr  = bus.addr_in[1:0];
                sel_wdata = bus.wdata_in[15:0];
                win_lock  = bus.lock[0];
                win_req   = bus.req[0];
            end
            2'd1: begin
                sel_wr    = bus.wr[1];
                sel_addr  = bus.addr_in[3:2];
                sel_wdata = bus.wdata_in[31:16];
                win_lock  = bus.lock[1];
                win_req   = bus.req[1];
            end
            default: begin
                sel_wr    = bus.wr[2];
                sel_addr  = bus.addr_in[5:4];
                sel_wdata = bus.wdata_in[47:32];
                win_lock  = bus.lock[2];
                win_req   = bus.req[2];
            end
        endcase
    end

    // Timer reaches the limit on this idle HOLD cycle.
    always_comb begin
        timer_hit = (({1'b0, hold_timer} + 7'd1) >= {1'b0, TMO});
    end

    // Next-state logic; HOLD exits are prioritised lock, then req, then timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    next_state = ARB;
                end else begin
                    next_state = IDLE;
                end
            end
            ARB: begin
                if (|bus.req) begin
                    next_state = ACCESS;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS: begin
                if (win_lock) begin
                    next_state = HOLD;
                end else begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (!win_lock) begin
                    next_state = IDLE;
                end else if (win_req) begin
                    next_state = ACCESS;
                end else if (timer_hit) begin
                    next_state = IDLE;
                end else begin
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            win         <= 2'd0;
            gnt         <= 3'b000;
            done        <= 3'b000;
            rdata       <= 16'h0000;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != IDLE);
            done        <= 3'b000;
            timeout_err <= 1'b0;
            case (state)
                ARB: begin
                    win <= arb_idx;
                    gnt <= (|bus.req) ? onehot(arb_idx) : 3'b000;
                end
                ACCESS: begin
                    if (!sel_wr) begin
                        rdata <= store[sel_addr];
                    end
                    done <= onehot(win);
                    if (next_state == IDLE) begin
                        gnt <= 3'b000;
                    end
                end
                HOLD: begin
                    if (next_state == IDLE) begin
                        gnt <= 3'b000;
                    end
                    timeout_err <= win_lock && !win_req && timer_hit;
                end
                default: gnt <= 3'b000;
            endcase
        end
    end

    // Hold timer: cleared by every access, counts idle HOLD cycles, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_timer <= 6'd0;
        end else begin
            case (state)
                ACCESS:  hold_timer <= 6'd0;
                HOLD:    hold_timer <= timer_hit ? TMO : (hold_timer + 6'd1);
                default: hold_timer <= hold_timer;
            endcase
        end
    end

    // Always-on store; word3 powers up with both flags set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store[0] <= 16'h0000;
            store[1] <= 16'h0000;
            store[2] <= 16'h0000;
            store[3] <= 16'h0003;
        end else if ((state == ACCESS) && sel_wr) begin
            store[sel_addr] <= sel_wdata;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.done        = done;
    assign bus.rdata       = rdata;
    assign bus.busy        = busy;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_aon_mem_arbiter.sv
// Scoreboard bench for aon_mem_arbiter: transaction-level model predicts winners and read data.
module tb_aon_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aon_mem_arbiter_if bus();

    aon_mem_arbiter #(.TIMEOUT(63), .NREQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          tmo;
        int          who;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] mem [4];
    logic [15:0] last_rd;
    int          ptr;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mem[0]  = 16'h0000;
        mem[1]  = 16'h0000;
        mem[2]  = 16'h0000;
        mem[3]  = 16'h0003;
        last_rd = 16'h0000;
        ptr     = 2;
    endfunction

    function automatic int pick(input logic [2:0] p);
`ifdef AON_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (ptr + k) % 3;
            if (p[idx]) return idx;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (p[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic set_fields(input int i, input logic w, input logic [1:0] a, input logic [15:0] d);
        bus.wr[i]                = w;
        bus.addr_in[2*i +: 2]    = a;
        bus.wdata_in[16*i +: 16] = d;
    endtask

    // Apply requester's current fields to the model and queue the expected completion.
    task automatic model_access(input int who, input bit arb);
        exp_t        e;
        logic        w;
        logic [1:0]  a;
        logic [15:0] d;
        w = bus.wr[who];
        a = bus.addr_in[2*who +: 2];
        d = bus.wdata_in[16*who +: 16];
        if (w) mem[a] = d;
        else   last_rd = mem[a];
        e.tmo  = 1'b0;
        e.who  = who;
        e.data = last_rd;
        sbq.push_back(e);
        if (arb) ptr = who;
    endtask

    task automatic wait_done(output logic [2:0] d);
        d = 3'b000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|bus.done) begin
                d = bus.done;
                break;
            end
        end
        n_checks++;
        if (d == 3'b000) begin
            n_fail++;
            $display("FAIL done_wait: no done within 20 cycles");
            sbq.delete();
        end
    endtask

    task automatic one_access(input int i, input logic w, input logic [1:0] a, input logic [15:0] d);
        logic [2:0] dd;
        set_fields(i, w, a, d);
        model_access(i, 1'b1);
        bus.req = 3'(1 << i);
        wait_done(dd);
        bus.req = 3'b000;
        @(negedge clk);
    endtask

    task automatic rand_round();
        logic [2:0] pend;
        logic [2:0] tmp;
        logic [2:0] d;
        int         w;
        pend = 3'($urandom_range(1, 7));
        for (int i = 0; i < 3; i++)
            set_fields(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
        tmp = pend;
        while (tmp != 3'b000) begin
            w = pick(tmp);
            model_access(w, 1'b1);
            tmp[w] = 1'b0;
        end
        bus.req = pend;
        while (pend != 3'b000) begin
            wait_done(d);
            if (d == 3'b000) pend = 3'b000;
            else             pend = pend & ~d;
            bus.req = pend;
        end
        @(negedge clk);
    endtask

    // Monitor: every completion or timeout pops the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if ((|bus.done) || bus.timeout_err)
                check("done_tmo_exclusive", {47'd0, (|bus.done) & bus.timeout_err}, 48'd0);
            if (|bus.done) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got %b with empty scoreboard", bus.done);
                end else begin
                    mon_e = sbq.pop_front();
                    check("done_who", bus.done, mon_e.tmo ? 48'd0 : 48'(1 << mon_e.who));
                    check("rdata", bus.rdata, mon_e.data);
                end
            end
            if (bus.timeout_err) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_timeout: scoreboard empty");
                end else begin
                    mon_e = sbq.pop_front();
                    check("timeout_expected", {47'd0, mon_e.tmo}, 48'd1);
                    check("timeout_rdata", bus.rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] d;
        exp_t       te;
        int         cnt;
        reset        = 1'b1;
        bus.req      = 3'b000;
        bus.lock     = 3'b000;
        bus.wr       = 3'b000;
        bus.addr_in  = 6'd0;
        bus.wdata_in = 48'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 3'b000);
        check("rst_done", bus.done, 3'b000);
        check("rst_rdata", bus.rdata, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_tmo", bus.timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Latency: read word3 via requester 1.
        set_fields(1, 1'b0, 2'd3, 16'h0000);
        model_access(1, 1'b1);
        bus.req = 3'b010;
        @(negedge clk);
        check("busy_c1", bus.busy, 1'b1);
        check("gnt_c1", bus.gnt, 3'b000);
        @(negedge clk);
        check("gnt_c2", bus.gnt, 3'b010);
        @(negedge clk);
        check("done_c3", bus.done, 3'b010);
        check("rdata_c3", bus.rdata, 16'h0003);
        bus.req = 3'b000;
        @(negedge clk);

        // Write by 0, read back by 2.
        one_access(0, 1'b1, 2'd1, 16'h002A);
        one_access(2, 1'b0, 2'd1, 16'h0000);
        check("rd_word1", bus.rdata, 16'h002A);

        // All three requesting, held for three accesses.
        for (int i = 0; i < 3; i++) set_fields(i, 1'b0, 2'(i + 1), 16'h0000);
        for (int n = 0; n < 3; n++) model_access(pick(3'b111), 1'b1);
        bus.req = 3'b111;
        for (int n = 0; n < 3; n++) begin
            wait_done(d);
            if (d == 3'b000) break;
        end
        bus.req = 3'b000;
        @(negedge clk);

        // Locked requester 2 goes quiet: hold timeout.
        bus.lock = 3'b100;
        set_fields(2, 1'b0, 2'($urandom_range(0, 3)), 16'h0000);
        model_access(2, 1'b1);
        bus.req = 3'b100;
        wait_done(d);
        bus.req = 3'b000;
        check("hold_gnt", bus.gnt, 3'b100);
        te.tmo = 1'b1; te.who = 2; te.data = last_rd;
        sbq.push_back(te);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            cnt++;
            if (bus.timeout_err) break;
        end
        check("timeout_latency", cnt, 63);
        check("timeout_gnt", bus.gnt, 3'b000);
        check("timeout_busy", bus.busy, 1'b0);
        bus.lock = 3'b000;
        @(negedge clk);

        // Locked requester 1 re-accesses without arbitration while requester 0 waits.
        bus.lock = 3'b010;
        set_fields(1, 1'b0, 2'd3, 16'h0000);
        model_access(1, 1'b1);
        bus.req = 3'b010;
        wait_done(d);
        set_fields(1, 1'b1, 2'd2, 16'hBEEF);
        set_fields(0, 1'b0, 2'd2, 16'h0000);
        model_access(1, 1'b0);
        bus.req = 3'b011;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt++;
            if (|bus.done) break;
        end
        check("reaccess_gap", cnt, 2);
        bus.req = 3'b001;
        repeat (5) @(negedge clk);
        check("hold_gnt_kept", bus.gnt, 3'b010);
        model_access(0, 1'b1);
        bus.lock = 3'b000;
        wait_done(d);
        bus.req = 3'b000;
        @(negedge clk);

        for (int r = 0; r < 40; r++) rand_round();

        // Reset in the middle of a write access.
        set_fields(0, 1'b1, 2'd0, 16'hFFFF);
        bus.req = 3'b001;
        @(negedge clk);
        @(negedge clk);
        check("access_gnt", bus.gnt, 3'b001);
        reset = 1'b1;
        #1;
        check("abort_gnt", bus.gnt, 3'b000);
        check("abort_busy", bus.busy, 1'b0);
        bus.req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        one_access(0, 1'b0, 2'd0, 16'h0000);
        check("word0_after_abort", bus.rdata, 16'h0000);
        one_access(2, 1'b0, 2'd3, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
